// File: rtl/matmul_sequencer.sv
// Run controller for the matrix-multiply accelerator.
// Detects a start request, checks the N/K/M dimensions, and sequences operand
// streaming, the systolic compute window and scratchpad write-back, then
// reports done or error and clears the control register start bit.
module matmul_sequencer #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned BUS_WIDTH      = 64,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       start_bit_i,
    input  logic [1:0] n_dim_i,
    input  logic [1:0] k_dim_i,
    input  logic [1:0] m_dim_i,
    input  logic       finish_send_a_i,
    input  logic       finish_send_b_i,
    input  logic       finish_send_c_i,
    output logic       start_send_a_o,
    output logic       start_send_b_o,
    output logic       start_send_c_o,
    output logic       compute_en_o,
    output logic [3:0] step_o,
    output logic       clear_start_o,
    output logic       busy_o,
    output logic       done_o,
    output logic       err_o
);

    localparam int unsigned MAX_DIM    = BUS_WIDTH / DATA_WIDTH;
    localparam int unsigned DIM_W      = 2;
    localparam int unsigned STEP_W     = 4;
    localparam int unsigned TIMER_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CHECK   = 3'd1,
        ST_LOAD    = 3'd2,
        ST_COMPUTE = 3'd3,
        ST_WBACK   = 3'd4,
        ST_DONE    = 3'd5,
        ST_ERROR   = 3'd6
    } state_t;

    state_t              state;
    state_t              state_next;
    logic                start_q;
    logic [DIM_W-1:0]    n_q;
    logic [DIM_W-1:0]    k_q;
    logic [DIM_W-1:0]    m_q;
    logic [DIM_W-1:0]    n_next;
    logic [DIM_W-1:0]    k_next;
    logic [DIM_W-1:0]    m_next;
    logic                got_a;
    logic                got_b;
    logic                got_a_next;
    logic                got_b_next;
    logic [TIMER_W-1:0]  timer;
    logic [TIMER_W-1:0]  timer_next;
    logic [STEP_W-1:0]   step;
    logic [STEP_W-1:0]   step_next;

    logic                start_rise;
    logic                load_done;
    logic                timer_expired;
    logic [STEP_W-1:0]   step_last;

    logic                start_send_ab_d;
    logic                start_send_c_d;
    logic                compute_en_d;
    logic [STEP_W-1:0]   step_d;
    logic                clear_start_d;
    logic                busy_d;
    logic                done_d;
    logic                err_d;

    // A dimension field fits when its actual size (field+1) is within MAX_DIM.
    function automatic logic dim_fits(input logic [DIM_W-1:0] field);
        return (32'(field) + 32'd1) <= MAX_DIM;
    endfunction

    assign start_rise    = start_bit_i & ~start_q;
    assign load_done     = (got_a | finish_send_a_i) & (got_b | finish_send_b_i);
    assign timer_expired = (timer == TIMER_LAST);
    // Last step index is LEN-1 = n+k+m+1 using the raw latched fields.
    assign step_last     = STEP_W'(n_q) + STEP_W'(k_q) + STEP_W'(m_q) + STEP_W'(1);

    // State, datapath and output registers; reset returns to IDLE with quiet outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state          <= ST_IDLE;
            // Track the live start level so a bit held across reset is not a new edge.
            start_q        <= start_bit_i;
            n_q            <= '0;
            k_q            <= '0;
            m_q            <= '0;
            got_a          <= 1'b0;
            got_b          <= 1'b0;
            timer          <= '0;
            step           <= '0;
            start_send_a_o <= 1'b0;
            start_send_b_o <= 1'b0;
            start_send_c_o <= 1'b0;
            compute_en_o   <= 1'b0;
            step_o         <= '0;
            clear_start_o  <= 1'b0;
            busy_o         <= 1'b0;
            done_o         <= 1'b0;
            err_o          <= 1'b0;
        end else begin
            state          <= state_next;
            start_q        <= start_bit_i;
            n_q            <= n_next;
            k_q            <= k_next;
            m_q            <= m_next;
            got_a          <= got_a_next;
            got_b          <= got_b_next;
            timer          <= timer_next;
            step           <= step_next;
            start_send_a_o <= start_send_ab_d;
            start_send_b_o <= start_send_ab_d;
            start_send_c_o <= start_send_c_d;
            compute_en_o   <= compute_en_d;
            step_o         <= step_d;
            clear_start_o  <= clear_start_d;
            busy_o         <= busy_d;
            done_o         <= done_d;
            err_o          <= err_d;
        end
    end

    // Next-state logic plus dimension latch, load tracking, phase timer and step counter.
    always_comb begin
        state_next = state;
        n_next     = n_q;
        k_next     = k_q;
        m_next     = m_q;
        got_a_next = got_a;
        got_b_next = got_b;
        timer_next = timer;
        step_next  = step;

        case (state)
            ST_IDLE: begin
                if (start_rise) begin
                    state_next = ST_CHECK;
                    n_next     = n_dim_i;
                    k_next     = k_dim_i;
                    m_next     = m_dim_i;
                    got_a_next = 1'b0;
                    got_b_next = 1'b0;
                    timer_next = '0;
                    step_next  = '0;
                end
            end

            ST_CHECK: begin
                if (dim_fits(n_q) && dim_fits(k_q) && dim_fits(m_q)) begin
                    state_next = ST_LOAD;
                end else begin
                    state_next = ST_ERROR;
                end
            end

            ST_LOAD: begin
                got_a_next = got_a | finish_send_a_i;
                got_b_next = got_b | finish_send_b_i;
                if (load_done) begin
                    state_next = ST_COMPUTE;
                    timer_next = '0;
                    step_next  = '0;
                end else if (timer_expired) begin
                    state_next = ST_ERROR;
                end else begin
                    timer_next = timer + TIMER_W'(1);
                end
            end

            ST_COMPUTE: begin
                if (step == step_last) begin
                    state_next = ST_WBACK;
                    timer_next = '0;
                    step_next  = '0;
                end else begin
                    step_next = step + STEP_W'(1);
                end
            end

            ST_WBACK: begin
                if (finish_send_c_i) begin
                    state_next = ST_DONE;
                end else if (timer_expired) begin
                    state_next = ST_ERROR;
                end else begin
                    timer_next = timer + TIMER_W'(1);
                end
            end

            ST_DONE: begin
                state_next = ST_IDLE;
            end

            ST_ERROR: begin
                state_next = ST_IDLE;
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Output values for the upcoming state, registered alongside the state.
    always_comb begin
        start_send_ab_d = 1'b0;
        start_send_c_d  = 1'b0;
        compute_en_d    = 1'b0;
        step_d          = '0;
        clear_start_d   = 1'b0;
        busy_d          = (state_next != ST_IDLE);
        done_d          = 1'b0;
        err_d           = err_o;

        // Operand streams start during CHECK only when the dimensions are legal.
        if (state_next == ST_CHECK) begin
            start_send_ab_d = dim_fits(n_next) && dim_fits(k_next) && dim_fits(m_next);
        end

        if (state == ST_IDLE && state_next == ST_CHECK) begin
            err_d = 1'b0;
        end

        if (state_next == ST_COMPUTE) begin
            compute_en_d = 1'b1;
            step_d       = step_next;
        end

        if (state == ST_COMPUTE && state_next == ST_WBACK) begin
            start_send_c_d = 1'b1;
        end

        if (state_next == ST_DONE) begin
            done_d        = 1'b1;
            clear_start_d = 1'b1;
        end

        if (state_next == ST_ERROR) begin
            err_d         = 1'b1;
            clear_start_d = 1'b1;
        end
    end

endmodule

// File: tb/tb_matmul_sequencer.sv
// Directed bench for matmul_sequencer: table of dimension/handshake vectors
// followed by hand-written timeout, reset and stray-pulse sequences.
module tb_matmul_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       start_bit;
    logic [1:0] n_dim;
    logic [1:0] k_dim;
    logic [1:0] m_dim;
    logic       finish_a;
    logic       finish_b;
    logic       finish_c;
    logic       start_a;
    logic       start_b;
    logic       start_c;
    logic       compute_en;
    logic [3:0] step;
    logic       clear_start;
    logic       busy;
    logic       done;
    logic       err;

    int n_checks = 0;
    int n_fail   = 0;

    matmul_sequencer #(
        .DATA_WIDTH    (32),
        .BUS_WIDTH     (64),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .start_bit_i    (start_bit),
        .n_dim_i        (n_dim),
        .k_dim_i        (k_dim),
        .m_dim_i        (m_dim),
        .finish_send_a_i(finish_a),
        .finish_send_b_i(finish_b),
        .finish_send_c_i(finish_c),
        .start_send_a_o (start_a),
        .start_send_b_o (start_b),
        .start_send_c_o (start_c),
        .compute_en_o   (compute_en),
        .step_o         (step),
        .clear_start_o  (clear_start),
        .busy_o         (busy),
        .done_o         (done),
        .err_o          (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] n;
        logic [1:0] k;
        logic [1:0] m;
        int         da;   // LOAD cycle index carrying finish_a
        int         db;   // LOAD cycle index carrying finish_b
        int         dc;   // WBACK cycle index carrying finish_c
        bit         ok;   // dimensions legal for MAX_DIM = 2
        int         len;  // expected compute window length
    } vec_t;

    vec_t vecs[8];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic run_vec(input vec_t v, input bit hold);
        int lmax;
        n_dim = v.n;
        k_dim = v.k;
        m_dim = v.m;
        start_bit = 1'b1;
        tick();
        check("check_send_a", int'(start_a), int'(v.ok));
        check("check_send_b", int'(start_b), int'(v.ok));
        check("check_busy", int'(busy), 1);
        check("check_err_cleared", int'(err), 0);
        if (!v.ok) begin
            tick();
            check("error_err", int'(err), 1);
            check("error_clear_start", int'(clear_start), 1);
            check("error_done", int'(done), 0);
            check("error_no_send", int'(start_a | start_b | start_c), 0);
            tick();
            check("error_idle_busy", int'(busy), 0);
            check("error_sticky", int'(err), 1);
            check("error_clear_pulse", int'(clear_start), 0);
        end else begin
            tick();
            lmax = (v.da > v.db) ? v.da : v.db;
            for (int i = 0; i <= lmax; i++) begin
                check("load_compute_en", int'(compute_en), 0);
                check("load_send_a_pulse", int'(start_a), 0);
                finish_a = (i == v.da);
                finish_b = (i == v.db);
                tick();
                finish_a = 1'b0;
                finish_b = 1'b0;
            end
            for (int s = 0; s < v.len; s++) begin
                check("compute_en", int'(compute_en), 1);
                check("compute_step", int'(step), s);
                tick();
            end
            check("wback_compute_off", int'(compute_en), 0);
            check("wback_step_zero", int'(step), 0);
            check("wback_send_c", int'(start_c), 1);
            for (int j = 0; j <= v.dc; j++) begin
                if (j > 0) check("wback_send_c_pulse", int'(start_c), 0);
                check("wback_no_done", int'(done), 0);
                finish_c = (j == v.dc);
                tick();
                finish_c = 1'b0;
            end
            check("done_pulse", int'(done), 1);
            check("done_clear_start", int'(clear_start), 1);
            check("done_err", int'(err), 0);
            tick();
            check("idle_done", int'(done), 0);
            check("idle_busy", int'(busy), 0);
            check("idle_clear_start", int'(clear_start), 0);
        end
        if (!hold) begin
            start_bit = 1'b0;
            tick();
            check("idle_after_run", int'(busy), 0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = '{2'd1, 2'd1, 2'd1, 2, 4, 1, 1'b1, 5};
        vecs[1] = '{2'd0, 2'd0, 2'd0, 1, 1, 0, 1'b1, 2};
        vecs[2] = '{2'd2, 2'd0, 2'd0, 0, 0, 0, 1'b0, 0};
        vecs[3] = '{2'd0, 2'd1, 2'd0, 0, 3, 2, 1'b1, 3};
        vecs[4] = '{2'd1, 2'd0, 2'd1, 4, 0, 0, 1'b1, 4};
        vecs[5] = '{2'd0, 2'd3, 2'd0, 0, 0, 0, 1'b0, 0};
        vecs[6] = '{2'd0, 2'd0, 2'd2, 0, 0, 0, 1'b0, 0};
        vecs[7] = '{2'd1, 2'd1, 2'd0, 5, 2, 1, 1'b1, 4};

        rst = 1'b1;
        start_bit = 1'b0;
        n_dim = '0;
        k_dim = '0;
        m_dim = '0;
        finish_a = 1'b0;
        finish_b = 1'b0;
        finish_c = 1'b0;
        tick();
        tick();
        check("reset_busy", int'(busy), 0);
        check("reset_outputs", int'({start_a, start_b, start_c, compute_en, clear_start, done, err}), 0);
        check("reset_step", int'(step), 0);
        rst = 1'b0;
        tick();

        // Dimension/handshake table
        for (int v = 0; v < 8; v++) begin
            run_vec(vecs[v], 1'b0);
        end

        // LOAD timeout: only finish_b returns
        n_dim = 2'd0; k_dim = 2'd0; m_dim = 2'd0;
        start_bit = 1'b1;
        tick();
        tick();
        for (int i = 0; i < 16; i++) begin
            check("to_wait_err", int'(err), 0);
            check("to_wait_busy", int'(busy), 1);
            finish_b = (i == 0);
            tick();
            finish_b = 1'b0;
        end
        check("to_err", int'(err), 1);
        check("to_clear_start", int'(clear_start), 1);
        check("to_no_done", int'(done), 0);
        check("to_no_compute", int'(compute_en), 0);
        tick();
        check("to_idle", int'(busy), 0);
        start_bit = 1'b0;
        tick();

        // finish_a in the expiry cycle wins; then WBACK times out
        start_bit = 1'b1;
        tick();
        check("exp_err_cleared", int'(err), 0);
        tick();
        for (int i = 0; i < 16; i++) begin
            finish_b = (i == 0);
            finish_a = (i == 15);
            tick();
            finish_a = 1'b0;
            finish_b = 1'b0;
        end
        check("exp_compute", int'(compute_en), 1);
        check("exp_no_err", int'(err), 0);
        check("exp_step0", int'(step), 0);
        tick();
        tick();
        check("exp_send_c", int'(start_c), 1);
        for (int i = 0; i < 16; i++) begin
            check("wb_to_wait", int'(err), 0);
            tick();
        end
        check("wb_to_err", int'(err), 1);
        check("wb_to_clear", int'(clear_start), 1);
        check("wb_to_done", int'(done), 0);
        tick();
        start_bit = 1'b0;
        tick();
        check("wb_to_idle", int'(busy), 0);

        // Reset during COMPUTE step 2 with start held high
        n_dim = 2'd1; k_dim = 2'd1; m_dim = 2'd1;
        start_bit = 1'b1;
        tick();
        tick();
        finish_a = 1'b1;
        finish_b = 1'b1;
        tick();
        finish_a = 1'b0;
        finish_b = 1'b0;
        tick();
        tick();
        check("rst_pre_step", int'(step), 2);
        rst = 1'b1;
        tick();
        check("rst_busy", int'(busy), 0);
        check("rst_outputs", int'({start_a, start_b, start_c, compute_en, clear_start, done, err}), 0);
        check("rst_step", int'(step), 0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_held_no_restart", int'(busy | start_a), 0);
        end
        start_bit = 1'b0;
        tick();
        start_bit = 1'b1;
        tick();
        check("rst_restart_busy", int'(busy), 1);
        check("rst_restart_send_a", int'(start_a), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        start_bit = 1'b0;
        tick();

        // Stray pulses and start held through completion
        finish_a = 1'b1;
        finish_c = 1'b1;
        tick();
        finish_a = 1'b0;
        finish_c = 1'b0;
        check("stray_idle_busy", int'(busy), 0);
        n_dim = 2'd0; k_dim = 2'd0; m_dim = 2'd0;
        start_bit = 1'b1;
        tick();
        tick();
        finish_b = 1'b1;
        tick();
        finish_b = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("stray_no_preset", int'(compute_en), 0);
            tick();
        end
        finish_a = 1'b1;
        tick();
        finish_a = 1'b0;
        check("stray_compute", int'(compute_en), 1);
        finish_c = 1'b1;
        tick();
        finish_c = 1'b0;
        check("stray_c_in_compute", int'(step), 1);
        check("stray_c_compute_en", int'(compute_en), 1);
        tick();
        check("hold_send_c", int'(start_c), 1);
        finish_c = 1'b1;
        tick();
        finish_c = 1'b0;
        check("hold_done", int'(done), 1);
        tick();
        check("hold_idle", int'(busy), 0);
        for (int i = 0; i < 4; i++) begin
            finish_c = (i == 1);
            tick();
            finish_c = 1'b0;
            check("hold_no_rerun", int'(busy | start_a | done), 0);
        end
        start_bit = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
